// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding, opcode constants and datapath mux encodings for the
// multicycle MIPS main control FSM.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPE_EX,
        RTYPE_WB,
        BEQ_EX,
        ADDI_EX,
        ADDI_WB,
        JUMP_EX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Memory watchdog: counts stalled cycles in a wait state and flags expiry
// combinationally in the cycle the budget runs out (mem_ready overrides).
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = count_en && !ready && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with memory watchdog and
// retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             tmr_clear;
    logic             tmr_count_en;
    logic             tmr_expired;

    // Clear only on entry, so MEMWR->FETCH still restarts the budget.
    assign tmr_clear    = is_wait_state(state_d) && (state_d != state_q);
    assign tmr_count_en = is_wait_state(state_q);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .count_en(tmr_count_en),
        .ready   (mem_ready),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        mem_err       = tmr_expired;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)        state_d = DECODE;
                else if (tmr_expired) state_d = IDLE;
            end
            DECODE: begin
                alu_src_b = SRCB_BOFS;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_BEQ:       state_d = BEQ_EX;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP_EX;
                    default: begin
                        state_d    = IDLE;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)        state_d = MEMWB;
                else if (tmr_expired) state_d = IDLE;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            BEQ_EX: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JUMP_EX: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = IDLE;
        endcase

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;

endmodule
